// File: rtl/apb_slv_regs.sv
// apb_slv_regs: APB3 completer holding a small 32-bit register file.
//  Word 0 is a read-only ID, word 1 a read-only completed-transfer counter,
//  words 2..NREGS-1 are read/write storage. WAIT_CYC wait states are inserted
//  per access phase through pready; illegal accesses answer with pslverr.
// Ports:
//  clk, rst          clock (rising edge), async active-low reset
//  psel, penable     APB select / access-phase strobes
//  pwrite            1 = write, 0 = read
//  paddr, pwdata     byte address (bits [1:0] ignored), write data
//  prdata            read data, non-zero only on a completing legal read
//  pready, pslverr   transfer completion and error response
module apb_slv_regs #(
  parameter int unsigned NREGS     = 8,
  parameter int unsigned AW        = 3,
  parameter logic [31:0] BASE_ADDR = 32'hDEADCAE0,
  parameter int unsigned WAIT_CYC  = 1,
  parameter logic [31:0] ID_VAL    = 32'hA9B0_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int unsigned DW = 32;
  // A zero-wait build still keeps a 1-bit counter so no zero-width vector appears.
  localparam int unsigned CW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   words_q [NREGS];
  logic [DW-1:0]   xfer_cnt_q;
  logic [DW-1:0]   rd_word;
  logic [AW-1:0]   idx;
  logic            hit;
  logic            err;
  logic            done;
  logic            wr_en;
  logic            unused_addr_lsb;

  // Address decode and error classification.
  assign hit             = (paddr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign idx             = paddr[AW+1:2];
  assign err             = !hit || (pwrite && (idx < AW'(2)));
  assign wr_en           = done && pwrite && !err;
  assign unused_addr_lsb = ^paddr[1:0];

  // Read mux: words 0 and 1 are not storage.
  always_comb begin
    rd_word = words_q[idx];
    if (idx == AW'(0)) begin
      rd_word = ID_VAL;
    end else if (idx == AW'(1)) begin
      rd_word = xfer_cnt_q;
    end
  end

  // Next-state, wait counter and bus response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_LOAD;
        end else if (psel && penable) begin
          // Access phase with no setup: answer at once with an error.
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (!penable) begin
          // Setup re-issued without an access phase: restart the wait.
          cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
          pready  = 1'b1;
          pslverr = err;
          if (!pwrite && !err) begin
            prdata = rd_word;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Responses are silenced for the whole time reset is asserted.
    if (!rst) begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Completed-transfer counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt_q <= '0;
    end else if (done) begin
      xfer_cnt_q <= xfer_cnt_q + DW'(1);
    end
  end

  // Register storage; legal writes only ever target words 2 and up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        words_q[i] <= '0;
      end
    end else if (wr_en) begin
      words_q[idx] <= pwdata;
    end
  end

endmodule

// File: tb/tb_apb_slv_regs.sv
module tb_apb_slv_regs;

  localparam int unsigned NREGS    = 8;
  localparam int unsigned AW       = 3;
  localparam int unsigned WAIT_CYC = 1;
  localparam logic [31:0] BASE     = 32'hDEADCAE0;
  localparam logic [31:0] ID       = 32'hA9B0_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  apb_slv_regs #(
    .NREGS(NREGS), .AW(AW), .BASE_ADDR(BASE), .WAIT_CYC(WAIT_CYC), .ID_VAL(ID)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] m_words [NREGS];
  logic [31:0] m_cnt;
  logic        exp_pready, exp_pslverr;
  logic [31:0] exp_prdata;
  bit          chk_on = 1'b0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of the bus response against the expectation.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pready", 32'(pready), 32'(exp_pready));
      chk("pslverr", 32'(pslverr), 32'(exp_pslverr));
      chk("prdata", prdata, exp_prdata);
    end
  end

  // Reference model of the register map.
  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(NREGS * 4));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit m_err(input logic [31:0] a, input logic w);
    return !m_hit(a) || (w && (m_idx(a) < 2));
  endfunction

  function automatic logic [31:0] m_read(input int i);
    if (i == 0) return ID;
    if (i == 1) return m_cnt;
    return m_words[i];
  endfunction

  task automatic m_reset();
    m_cnt = 32'h0;
    for (int i = 0; i < int'(NREGS); i++) m_words[i] = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_quiet();
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      psel = 1'b0; penable = 1'b0;
      exp_quiet();
    end
  endtask

  // Full transfer: setup, WAIT_CYC wait cycles, completing cycle.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
    bit e;
    e = m_err(a, w);
    step();
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    exp_quiet();
    for (int k = 0; k <= int'(WAIT_CYC); k++) begin
      step();
      penable = 1'b1;
      if (k < int'(WAIT_CYC)) begin
        exp_quiet();
      end else begin
        exp_pready  = 1'b1;
        exp_pslverr = e;
        exp_prdata  = (!w && !e) ? m_read(m_idx(a)) : 32'h0;
      end
    end
    @(negedge clk);
    last_rdata = prdata;
    last_err   = pslverr;
    if (w && !e) m_words[m_idx(a)] = d;
    m_cnt = m_cnt + 32'h1;
  endtask

  // Setup plus j access cycles, then psel drops before completion.
  task automatic abort_xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input int j);
    step();
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    exp_quiet();
    for (int k = 0; k < j; k++) begin
      step();
      penable = 1'b1;
      exp_quiet();
    end
    step();
    psel = 1'b0; penable = 1'b0;
    exp_quiet();
  endtask

  // Access phase presented without a preceding setup.
  task automatic no_setup(input logic [31:0] a, input logic w, input logic [31:0] d);
    step();
    psel = 1'b1; penable = 1'b1; pwrite = w; paddr = a; pwdata = d;
    exp_pready = 1'b1; exp_pslverr = 1'b1; exp_prdata = 32'h0;
    @(negedge clk);
    last_err = pslverr;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    exp_quiet();
    m_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int          r;
    logic        w;

    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    exp_quiet();
    m_reset();
    chk_on = 1'b1;
    step();
    step();
    rst = 1'b1;
    idle(1);

    // ID word read with one wait state.
    xfer(32'hDEADCAE0, 1'b0, 32'h0);
    chk("t1_id", last_rdata, 32'hA9B00001);
    chk("t1_err", 32'(last_err), 32'h0);

    // Write/read word 7 through the fixed master address, then the counter.
    do_reset();
    xfer(32'hDEADCAFE, 1'b1, 32'h12345678);
    xfer(32'hDEADCAFE, 1'b0, 32'h0);
    chk("t2_rd", last_rdata, 32'h12345678);
    xfer(32'hDEADCAE4, 1'b0, 32'h0);
    chk("t2_cnt", last_rdata, 32'h2);

    // Write to a read-only word and read outside the region.
    xfer(32'hDEADCAE4, 1'b1, 32'h5);
    chk("t3_wr_err", 32'(last_err), 32'h1);
    xfer(32'hDEADC000, 1'b0, 32'h0);
    chk("t3_rd_err", 32'(last_err), 32'h1);
    chk("t3_rd_zero", last_rdata, 32'h0);
    xfer(32'hDEADCAE4, 1'b0, 32'h0);
    chk("t3_cnt", last_rdata, 32'h5);

    // Back-to-back writes with no idle cycle in between.
    for (int v = 1; v <= 5; v++) xfer(32'hDEADCAFE, 1'b1, 32'(v));
    xfer(32'hDEADCAFE, 1'b0, 32'h0);
    chk("t4_rd", last_rdata, 32'h5);

    // Reset in the middle of a write's wait cycle.
    step();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hDEADCAFE; pwdata = 32'hAAAA5555;
    exp_quiet();
    step();
    penable = 1'b1;
    #2;
    rst = 1'b0;
    m_reset();
    step();
    step();
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    xfer(32'hDEADCAE4, 1'b0, 32'h0);
    chk("t5_cnt", last_rdata, 32'h0);
    xfer(32'hDEADCAFE, 1'b0, 32'h0);
    chk("t5_word", last_rdata, 32'h0);

    // No-setup access, aborted transfers, counter wrap.
    no_setup(32'hDEADCAE8, 1'b1, 32'h77);
    chk("t6_nosetup_err", 32'(last_err), 32'h1);
    abort_xfer(32'hDEADCAE8, 1'b1, 32'h55, 1);
    abort_xfer(32'hDEADCAE8, 1'b1, 32'h66, 0);
    xfer(32'hDEADCAE8, 1'b0, 32'h0);
    chk("t6_no_commit", last_rdata, 32'h0);
    xfer(32'hDEADCAE4, 1'b0, 32'h0);
    chk("t6_cnt", last_rdata, 32'h3);
    step();
    psel = 1'b0; penable = 1'b0;
    exp_quiet();
    dut.xfer_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    xfer(32'hDEADCAE4, 1'b0, 32'h0);
    chk("t6_cnt_max", last_rdata, 32'hFFFF_FFFF);
    xfer(32'hDEADCAE4, 1'b0, 32'h0);
    chk("t6_cnt_wrap", last_rdata, 32'h0);

    // Randomized mix against the model.
    repeat (300) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 9) < 8)
        a = BASE + 32'($urandom_range(0, NREGS - 1) * 4) + 32'($urandom_range(0, 3));
      else
        a = $urandom;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (r < 65) xfer(a, w, d);
      else if (r < 78) abort_xfer(a, w, d, int'($urandom_range(0, WAIT_CYC)));
      else if (r < 88) no_setup(a, w, d);
      else idle(int'($urandom_range(1, 3)));
    end

    for (int i = 0; i < int'(NREGS); i++) begin
      xfer(BASE + 32'(i * 4), 1'b0, 32'h0);
    end
    idle(2);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
